truth_table_sweeper: RTL and testbench
======================================

// Module: truth_table_sweeper
// PURPOSE
//  Sequential stimulus/capture stage wrapped around a combinational Boolean block (A,B,C -> F).
//  - On start, drives every input combination 000..111 in binary order, waits a settle time, then samples F.
//  - Builds the complete truth table in a register.
//  - Lets the lab board exercise a Boolean function in hardware, with no testbench driving the inputs.
// PARAMETERS
//  N_IN           3      number of function inputs; N_VEC = 2**N_IN vectors
//  SETTLE_CYCLES  4      clk cycles each vector is held before F is sampled; legal range >=1
//  EXPECTED       8'h96  golden truth table, bit k = F(k); used only with SWEEP_CHECK_EN
// PORTS
//  clk         in   1       system clock, rising edge
//  rst_n       in   1       asynchronous, active-low reset
//  start_i     in   1       begin sweep; sampled only in IDLE
//  abc_o       out  N_IN    drives function inputs; MSB = A, LSB = C
//  f_i         in   1       function output F, from the combinational block under test
//  busy_o      out  1       high from the cycle after start is accepted until DONE is left
//  done_o      out  1       one-cycle pulse when the table is complete
//  table_o     out  N_VEC   captured truth table; bit k = F for abc_o == k
//  mismatch_o  out  1       only with SWEEP_CHECK_EN; high when table_o != EXPECTED
// BEHAVIOUR
//  Reset and outputs:
//  - Reset (async assert, sync deassert handled upstream): state = IDLE, abc_o = 0, busy_o = 0,
//    done_o = 0, table_o = 0, mismatch_o = 0, idx = 0, cnt = 0.
//  - All outputs are registered.
//  State machine:
//  - IDLE: if start_i, then table_o <= 0, idx <= 0, abc_o <= 0, cnt <= 0, go to SETTLE. Otherwise hold.
//  - SETTLE: cnt increments each cycle. When cnt == SETTLE_CYCLES-1, go to SAMPLE.
//  - SAMPLE (1 cycle): table_o[idx] <= f_i.
//    - If idx == N_VEC-1, go to DONE.
//    - Else idx <= idx+1, abc_o <= idx+1, cnt <= 0, go to SETTLE.
//  - DONE (1 cycle): done_o = 1, abc_o <= 0, go to IDLE.
//  Timing and latency:
//  - Each vector costs SETTLE_CYCLES+1 cycles.
//  - done_o is high exactly N_VEC*(SETTLE_CYCLES+1)+1 cycles after the start edge; 41 at defaults.
//  Boundary conditions:
//  - start_i while busy (SETTLE/SAMPLE/DONE) is ignored; no restart and no queueing.
//  - start_i held high continuously starts a new sweep in the first IDLE cycle after DONE.
//  - table_o holds its last value in IDLE and is cleared only when a new start is accepted.
//  - idx is $clog2(N_VEC)+1 bits wide, so the compare idx == N_VEC-1 never wraps.
//  - abc_o is the low N_IN bits of idx.
//  - Reset mid-sweep aborts immediately: no done_o pulse, and the partial table is discarded (table_o = 0).
// CONFIGURATION
//  SWEEP_CHECK_EN defined:
//  - mismatch_o is present and registered in DONE as (table_o_next != EXPECTED).
//  - mismatch_o holds until the next accepted start, which clears it.
//  SWEEP_CHECK_EN undefined:
//  - The mismatch_o port and the EXPECTED compare logic are absent.
//  - EXPECTED is unused.
// STRUCTURE
//  - Package tts_pkg: typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} tts_state_t;
//    function n_vec(n) = 2**n.
//  - Sub-module tts_settle_timer: load/count/expire counter of width $clog2(SETTLE_CYCLES)+1.
//    It asserts expire_o when the count reaches SETTLE_CYCLES-1.
//  - The top holds the FSM, idx, and the table register.
// TESTING
//  1. f_i = A&B model, start pulse -> table_o = 8'hC0, done_o pulse at cycle 41, busy_o low the cycle after.
//  2. f_i = A^B^C -> table_o = 8'h96; abc_o steps 0..7, each value held exactly 5 cycles.
//  3. Second start_i pulse at cycle 10 of a sweep -> ignored; single done_o at cycle 41, table unchanged.
//  4. rst_n low at cycle 20 -> all outputs 0 asynchronously; no done_o; a fresh start completes normally.
//  5. SETTLE_CYCLES = 1, f_i = ~C -> table_o = 8'h55, done_o at cycle 17.
//  6. SWEEP_CHECK_EN: f_i = A^B^C -> mismatch_o = 0; f_i = A|B -> table 8'hFC, mismatch_o = 1.

Source files
------------

// File: rtl/tts_pkg.sv
// Shared state encoding and sizing helper for the truth-table sweeper.
package tts_pkg;

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} tts_state_t;

    function automatic int n_vec(input int n);
        return 2 ** n;
    endfunction

endpackage

// File: rtl/tts_settle_timer.sv
// Settle counter: load clears, en advances; expire_o when count reaches SETTLE_CYCLES-1.
// Latency: expire_o is combinational from the count register.
// Backpressure: none; the count saturates at its terminal value while en_i stays high.
module tts_settle_timer #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CW = $clog2(SETTLE_CYCLES) + 1;
    localparam logic [CW-1:0] LAST = CW'(SETTLE_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == LAST);

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps abc_o through all input vectors, samples f_i after a settle time, builds table_o.
// Latency: done_o pulses N_VEC*(SETTLE_CYCLES+1)+1 cycles after start; start ignored while busy.
// Option: SWEEP_CHECK_EN adds mismatch_o, comparing the finished table against EXPECTED.
module truth_table_sweeper
    import tts_pkg::*;
#(
    parameter int N_IN          = 3,
    parameter int SETTLE_CYCLES = 4
`ifdef SWEEP_CHECK_EN
    ,
    parameter logic [n_vec(N_IN)-1:0] EXPECTED = 8'h96
`endif
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    output logic [N_IN-1:0]        abc_o,
    input  logic                   f_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [n_vec(N_IN)-1:0] table_o
`ifdef SWEEP_CHECK_EN
    ,
    output logic                   mismatch_o
`endif
);

    localparam int N_VEC = n_vec(N_IN);
    localparam int IW    = $clog2(N_VEC) + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N_VEC - 1);

    tts_state_t       state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [N_IN-1:0]  abc_q, abc_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [N_VEC-1:0] table_q, table_d;
    logic             tmr_load, tmr_en, tmr_expire;
`ifdef SWEEP_CHECK_EN
    logic             mismatch_q, mismatch_d;
`endif

    tts_settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (tmr_load),
        .en_i    (tmr_en),
        .expire_o(tmr_expire)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        abc_d    = abc_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        table_d  = table_q;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
`ifdef SWEEP_CHECK_EN
        mismatch_d = mismatch_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d  = SETTLE;
                    table_d  = '0;
                    idx_d    = '0;
                    abc_d    = '0;
                    busy_d   = 1'b1;
                    tmr_load = 1'b1;
`ifdef SWEEP_CHECK_EN
                    mismatch_d = 1'b0;
`endif
                end
            end
            SETTLE: begin
                tmr_en = 1'b1;
                if (tmr_expire) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                table_d[idx_q[IW-2:0]] = f_i;
                // done_o and the cleared abc_o appear together with the DONE state
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    abc_d   = '0;
`ifdef SWEEP_CHECK_EN
                    mismatch_d = (table_d != EXPECTED);
`endif
                end else begin
                    state_d  = SETTLE;
                    idx_d    = idx_q + 1'b1;
                    abc_d    = idx_d[N_IN-1:0];
                    tmr_load = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            abc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            table_q <= '0;
`ifdef SWEEP_CHECK_EN
            mismatch_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            abc_q   <= abc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            table_q <= table_d;
`ifdef SWEEP_CHECK_EN
            mismatch_q <= mismatch_d;
`endif
        end
    end

    assign abc_o   = abc_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign table_o = table_q;
`ifdef SWEEP_CHECK_EN
    assign mismatch_o = mismatch_q;
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: two instances (settle 4 and settle 1) driven from a vector table.
`timescale 1ns/1ps
module tb_truth_table_sweeper;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start_a, start_b;
    logic [2:0] abc_a, abc_b;
    logic       f_a, f_b;
    logic       busy_a, busy_b, done_a, done_b;
    logic [7:0] tab_a, tab_b;
`ifdef SWEEP_CHECK_EN
    logic       mis_a, mis_b;
`endif
    int         fn_a, fn_b;

    // 0: A&B  1: A^B^C  2: ~C  3: A|B
    function automatic logic model_f(input int fn, input logic [2:0] v);
        case (fn)
            0:       return v[2] & v[1];
            1:       return v[2] ^ v[1] ^ v[0];
            2:       return ~v[0];
            default: return v[2] | v[1];
        endcase
    endfunction

    assign f_a = model_f(fn_a, abc_a);
    assign f_b = model_f(fn_b, abc_b);

    truth_table_sweeper dut_a (
        .clk(clk), .rst_n(rst_n), .start_i(start_a), .abc_o(abc_a), .f_i(f_a),
        .busy_o(busy_a), .done_o(done_a), .table_o(tab_a)
`ifdef SWEEP_CHECK_EN
        , .mismatch_o(mis_a)
`endif
    );

    truth_table_sweeper #(.SETTLE_CYCLES(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start_i(start_b), .abc_o(abc_b), .f_i(f_b),
        .busy_o(busy_b), .done_o(done_b), .table_o(tab_b)
`ifdef SWEEP_CHECK_EN
        , .mismatch_o(mis_b)
`endif
    );

    logic       sel;
    logic       m_busy, m_done;
    logic [2:0] m_abc;
    logic [7:0] m_tab;
`ifdef SWEEP_CHECK_EN
    logic       m_mis;
`endif
    always_comb begin
        m_busy = sel ? busy_b : busy_a;
        m_done = sel ? done_b : done_a;
        m_abc  = sel ? abc_b  : abc_a;
        m_tab  = sel ? tab_b  : tab_a;
`ifdef SWEEP_CHECK_EN
        m_mis  = sel ? mis_b  : mis_a;
`endif
    end

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic sb_check(input string name, input logic [7:0] act);
        if (sb_q.size() == 0) begin
            check({name, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            check(name, act, sb_q.pop_front());
        end
    endtask

    task automatic drive_start(input logic v);
        if (sel) start_b = v;
        else     start_a = v;
    endtask

    typedef struct {
        int         fn;
        logic       which;
        logic [7:0] tab;
        int         lat;
        int         restart_at;
    } vec_t;

    vec_t vecs[5];

    task automatic run_sweep(input vec_t v);
        int         cyc, run, exp_v, s1;
        logic       got;
        logic [2:0] prev;
        s1  = v.which ? 2 : 5;
        sel = v.which;
        if (v.which) fn_b = v.fn;
        else         fn_a = v.fn;
        sb_q.push_back(v.tab);
        @(negedge clk);
        drive_start(1'b1);
        cyc = 0; got = 1'b0; run = 0; exp_v = 0; prev = '0;
        while (!got && cyc < 200) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (cyc == 1) drive_start(1'b0);
            if (v.restart_at != 0 && cyc == v.restart_at)     drive_start(1'b1);
            if (v.restart_at != 0 && cyc == v.restart_at + 1) drive_start(1'b0);
            if (m_done) begin
                got = 1'b1;
                check("done_latency", cyc, v.lat);
                check("busy_in_done", m_busy, 1);
                check("abc_last_hold", run, s1);
                check("abc_last_value", exp_v, 7);
                check("abc_after_done", m_abc, 0);
                sb_check("table", m_tab);
`ifdef SWEEP_CHECK_EN
                check("mismatch", m_mis, (v.tab != 8'h96));
`endif
            end else if (cyc == 1) begin
                run = 1;
                check("abc_first", m_abc, 0);
                check("busy_after_start", m_busy, 1);
                check("table_cleared", m_tab, 0);
`ifdef SWEEP_CHECK_EN
                check("mismatch_cleared", m_mis, 0);
`endif
            end else if (m_abc == prev) begin
                run++;
            end else begin
                check("abc_hold", run, s1);
                check("abc_step", m_abc, exp_v + 1);
                exp_v++;
                run = 1;
            end
            prev = m_abc;
        end
        if (!got) check("done_timeout", 0, 1);
        @(negedge clk);
        check("done_pulse_width", m_done, 0);
        check("busy_low_after_done", m_busy, 0);
        repeat (3) @(negedge clk);
        check("table_hold_idle", m_tab, v.tab);
        check("no_extra_done", m_done, 0);
    endtask

    initial begin
        int   cyc, seen, ndone;
        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
        fn_a = 0; fn_b = 0; sel = 1'b0;

        vecs[0] = '{fn: 0, which: 1'b0, tab: 8'hC0, lat: 41, restart_at: 0};
        vecs[1] = '{fn: 1, which: 1'b0, tab: 8'h96, lat: 41, restart_at: 10};
        vecs[2] = '{fn: 2, which: 1'b1, tab: 8'h55, lat: 17, restart_at: 0};
        vecs[3] = '{fn: 3, which: 1'b0, tab: 8'hFC, lat: 41, restart_at: 0};
        vecs[4] = '{fn: 1, which: 1'b0, tab: 8'h96, lat: 41, restart_at: 0};

        #22;
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_abc", abc_a, 0);
        check("rst_table", tab_a, 0);
        check("rst_table_b", tab_b, 0);
`ifdef SWEEP_CHECK_EN
        check("rst_mismatch", mis_a, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) run_sweep(vecs[i]);

        // start held high: a second sweep begins right after the first IDLE cycle
        sel = 1'b0; fn_a = 0;
        sb_q.push_back(8'hC0);
        sb_q.push_back(8'hC0);
        @(negedge clk);
        start_a = 1'b1;
        cyc = 0; seen = 0;
        while (seen < 2 && cyc < 150) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (cyc == 42) check("hold_idle_gap", busy_a, 0);
            if (cyc == 43) begin
                check("hold_restart", busy_a, 1);
                start_a = 1'b0;
            end
            if (done_a) begin
                seen++;
                check(seen == 1 ? "hold_done1" : "hold_done2", cyc, seen == 1 ? 41 : 83);
                sb_check("hold_table", tab_a);
            end
        end
        if (seen < 2) check("hold_timeout", seen, 2);
        repeat (3) @(negedge clk);

        // reset in the middle of a sweep
        sel = 1'b0; fn_a = 1;
        @(negedge clk);
        start_a = 1'b1;
        cyc = 0;
        while (cyc < 20) begin
            @(posedge clk);
            cyc++;
            if (cyc == 1) begin
                @(negedge clk);
                start_a = 1'b0;
            end
        end
        #2;
        check("mid_busy_before_rst", busy_a, 1);
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy_a, 0);
        check("arst_abc", abc_a, 0);
        check("arst_table", tab_a, 0);
        check("arst_done", done_a, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (done_a) ndone++;
        end
        check("no_done_after_abort", ndone, 0);
        check("table_after_abort", tab_a, 0);
        run_sweep(vecs[4]);

        check("scoreboard_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
